wb_regfile: RTL

Writeback-stage consumer of the MEM/WB pipeline register outputs: holds the 32×32-bit general-purpose register file and the HI/LO special registers. It commits `wb_*` writes on the clock edge and serves the two ID-stage read ports and the HI/LO read port. Same-cycle WB→ID bypass means a value being written this cycle is visible to readers immediately, so no stall is needed for a 3-instruction-distant dependency.

---
 rtl/wb_regfile_pkg.sv | 21 ++
 rtl/wb_regfile_if.sv | 35 +++
 rtl/wb_regfile_hilo_reg.sv | 42 ++++
 rtl/wb_regfile.sv | 66 ++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared constants and bus types for the writeback-stage register file.
// Holds the control encodings and default widths used by the GPR array and HI/LO.
package wb_regfile_pkg;

  localparam int RegBusW  = 32;
  localparam int RegAddrW = 5;
  localparam int RegNum   = 32;

  localparam logic RstEnable    = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;

  typedef logic [RegBusW-1:0]  RegBus;
  typedef logic [RegAddrW-1:0] RegAddrBus;

  localparam RegBus     ZeroWord   = '0;
  localparam RegAddrBus NOPRegAddr = '0;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB writeback bus plus the ID-stage and HI/LO read ports of the register file.
// The master drives writes and read requests; the slave (register file) returns data.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic              wb_wreg;
  logic [ADDR_W-1:0] wb_wd;
  logic [DATA_W-1:0] wb_wdata;
  logic              wb_whilo;
  logic [DATA_W-1:0] wb_hi;
  logic [DATA_W-1:0] wb_lo;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output wb_wreg, wb_wd, wb_wdata, wb_whilo, wb_hi, wb_lo,
    output re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, hi_o, lo_o
  );

  modport slave (
    input  wb_wreg, wb_wd, wb_wdata, wb_whilo, wb_hi, wb_lo,
    input  re1, raddr1, re2, raddr2,
    output rdata1, rdata2, hi_o, lo_o
  );

endinterface

// File: rtl/wb_regfile_hilo_reg.sv
// HI/LO special-register pair, always written together, with same-cycle write bypass
// so a multiply/divide result committing this cycle is already visible to readers.
module hilo_reg
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = RegBusW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              whilo,
  input  logic [DATA_W-1:0] hi_wdata,
  input  logic [DATA_W-1:0] lo_wdata,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (whilo == WriteEnable) begin
      hi_q <= hi_wdata;
      lo_q <= lo_wdata;
    end
  end

  always_comb begin
    hi = hi_q;
    lo = lo_q;
    if (rst == RstEnable) begin
      hi = '0;
      lo = '0;
    end else if (whilo == WriteEnable) begin
      hi = hi_wdata;
      lo = lo_wdata;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback-stage GPR file: commits MEM/WB writes on the clock edge and serves two
// combinational ID-stage read ports with WB->ID bypass; HI/LO lives in hilo_reg.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = RegBusW,
  parameter int ADDR_W = RegAddrW,
  parameter int NREG   = RegNum
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);

  logic [DATA_W-1:0] regs [NREG];

  // Register 0 is hardwired to zero, so writes to it are dropped here.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.wb_wreg == WriteEnable && bus.wb_wd != '0) begin
      regs[bus.wb_wd] <= bus.wb_wdata;
    end
  end

  always_comb begin
    bus.rdata1 = regs[bus.raddr1];
    if (rst == RstEnable) begin
      bus.rdata1 = '0;
    end else if (bus.raddr1 == '0) begin
      bus.rdata1 = '0;
    end else if (bus.re1 == ReadDisable) begin
      bus.rdata1 = '0;
    end else if (bus.wb_wreg == WriteEnable && bus.wb_wd == bus.raddr1) begin
      bus.rdata1 = bus.wb_wdata;
    end
  end

  always_comb begin
    bus.rdata2 = regs[bus.raddr2];
    if (rst == RstEnable) begin
      bus.rdata2 = '0;
    end else if (bus.raddr2 == '0) begin
      bus.rdata2 = '0;
    end else if (bus.re2 == ReadDisable) begin
      bus.rdata2 = '0;
    end else if (bus.wb_wreg == WriteEnable && bus.wb_wd == bus.raddr2) begin
      bus.rdata2 = bus.wb_wdata;
    end
  end

  hilo_reg #(
    .DATA_W(DATA_W)
  ) u_hilo (
    .clk      (clk),
    .rst      (rst),
    .whilo    (bus.wb_whilo),
    .hi_wdata (bus.wb_hi),
    .lo_wdata (bus.wb_lo),
    .hi       (bus.hi_o),
    .lo       (bus.lo_o)
  );

endmodule
